seq_gen: RTL

- Serial pattern generator; the transmit-side counterpart of the codebase's serial sequence detectors.
- Accepts a programmable bit pattern through a valid/ready handshake.
- Shifts the pattern out one bit per clock, MSB first, and repeats it a programmable number of times with an idle gap between frames.
- Drives detector testbenches and any serial link that needs framed pattern injection.

---
 rtl/seq_gen_if.sv | 36 +++
 rtl/seq_gen.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/seq_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen_if
// Brief    : Request/serial-output bundle for the seq_gen pattern generator.
// Revision : 1.0
// ============================================================================
interface seq_gen_if #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int RPT_W   = 4,
    parameter int GAP_W   = 4
);
    logic               start_valid;
    logic               start_ready;
    logic [MAX_LEN-1:0] pat;
    logic [LEN_W-1:0]   pat_len;
    logic [RPT_W-1:0]   rpt;
    logic [GAP_W-1:0]   gap;
    logic               abort;
    logic               out;
    logic               out_valid;
    logic               out_last;
    logic               done;
    logic               busy;

    modport master (
        output start_valid, pat, pat_len, rpt, gap, abort,
        input  start_ready, out, out_valid, out_last, done, busy
    );

    modport slave (
        input  start_valid, pat, pat_len, rpt, gap, abort,
        output start_ready, out, out_valid, out_last, done, busy
    );
endinterface
`default_nettype wire

// File: rtl/seq_gen.sv
`default_nettype none
// ============================================================================
// Module   : seq_gen
// Brief    : Framed serial pattern generator, MSB first, with repeat count
//            and idle gap. Define SEQ_GEN_PARITY_EN to append an even-parity
//            bit to every frame.
// Revision : 1.0
// ============================================================================
module seq_gen #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4,
    parameter int RPT_W   = 4,
    parameter int GAP_W   = 4
) (
    input wire        clk,
    input wire        rst,
    seq_gen_if.slave  bus
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_send = 2'd1;
    localparam logic [1:0] c_gap  = 2'd2;
`ifdef SEQ_GEN_PARITY_EN
    localparam logic [1:0] c_par  = 2'd3;
    localparam logic       c_par_en = 1'b1;
`else
    localparam logic       c_par_en = 1'b0;
`endif

    localparam logic [LEN_W-1:0]   c_max_len = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   c_len_one = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [RPT_W-1:0]   c_frm_one = {{(RPT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0]   c_gap_one = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [MAX_LEN-1:0] c_pat_one = {{(MAX_LEN-1){1'b0}}, 1'b1};

    logic [1:0]         r_state;
    logic [MAX_LEN-1:0] r_pat;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_idx;
    logic [RPT_W-1:0]   r_frm;
    logic [GAP_W-1:0]   r_gap;
    logic [GAP_W-1:0]   r_gcnt;
    logic               r_out;
    logic               r_out_valid;
    logic               r_out_last;
    logic               r_done;
    logic               r_busy;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len;
    logic               w_frame_end;

    function automatic logic pick(input logic [MAX_LEN-1:0] v, input logic [LEN_W-1:0] i);
        pick = |(v & (c_pat_one << i));
    endfunction

    assign w_accept = bus.start_valid & bus.start_ready;
    assign w_len    = (bus.pat_len > c_max_len) ? c_max_len : bus.pat_len;

`ifdef SEQ_GEN_PARITY_EN
    logic               r_par;
    logic [MAX_LEN-1:0] w_mask;
    logic               w_par;
    // Only the low w_len bits belong to the frame.
    assign w_mask      = ~({MAX_LEN{1'b1}} << w_len);
    assign w_par       = ^(bus.pat & w_mask);
    assign w_frame_end = (r_state == c_par);
`else
    assign w_frame_end = (r_state == c_send) && (r_idx == '0);
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_idle;
            r_pat       <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_frm       <= '0;
            r_gap       <= '0;
            r_gcnt      <= '0;
            r_out       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_done      <= 1'b0;
            r_busy      <= 1'b0;
`ifdef SEQ_GEN_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            if (r_state == c_idle) begin
                if (w_accept) begin
                    r_pat <= bus.pat;
                    r_len <= w_len;
                    r_frm <= bus.rpt;
                    r_gap <= bus.gap;
`ifdef SEQ_GEN_PARITY_EN
                    r_par <= w_par;
`endif
                    if (w_len != '0) begin
                        r_state     <= c_send;
                        r_busy      <= 1'b1;
                        r_idx       <= w_len - c_len_one;
                        r_out       <= pick(bus.pat, w_len - c_len_one);
                        r_out_valid <= 1'b1;
                        r_out_last  <= !c_par_en && (w_len == c_len_one);
                    end else begin
                        r_done <= 1'b1;
                    end
                end
            end else if (bus.abort) begin
                r_state     <= c_idle;
                r_busy      <= 1'b0;
                r_out       <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else if (w_frame_end) begin
                if (r_frm != '0) begin
                    r_frm <= r_frm - c_frm_one;
                    if (r_gap != '0) begin
                        r_state     <= c_gap;
                        r_gcnt      <= r_gap;
                        r_out       <= 1'b0;
                        r_out_valid <= 1'b0;
                        r_out_last  <= 1'b0;
                    end else begin
                        // Back-to-back frame: reload with no idle cycle.
                        r_state     <= c_send;
                        r_idx       <= r_len - c_len_one;
                        r_out       <= pick(r_pat, r_len - c_len_one);
                        r_out_valid <= 1'b1;
                        r_out_last  <= !c_par_en && (r_len == c_len_one);
                    end
                end else begin
                    r_state     <= c_idle;
                    r_busy      <= 1'b0;
                    r_out       <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_done      <= 1'b1;
                end
            end else if (r_state == c_send) begin
                if (r_idx != '0) begin
                    r_idx       <= r_idx - c_len_one;
                    r_out       <= pick(r_pat, r_idx - c_len_one);
                    r_out_last  <= !c_par_en && (r_idx == c_len_one);
                end
`ifdef SEQ_GEN_PARITY_EN
                else begin
                    r_state    <= c_par;
                    r_out      <= r_par;
                    r_out_last <= 1'b1;
                end
`endif
            end else if (r_state == c_gap) begin
                if (r_gcnt == c_gap_one) begin
                    r_state     <= c_send;
                    r_idx       <= r_len - c_len_one;
                    r_out       <= pick(r_pat, r_len - c_len_one);
                    r_out_valid <= 1'b1;
                    r_out_last  <= !c_par_en && (r_len == c_len_one);
                end else begin
                    r_gcnt <= r_gcnt - c_gap_one;
                end
            end else begin
                r_state     <= c_idle;
                r_busy      <= 1'b0;
                r_out       <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.start_ready = (r_state == c_idle) & ~rst;
    assign bus.out         = r_out;
    assign bus.out_valid   = r_out_valid;
    assign bus.out_last    = r_out_last;
    assign bus.done        = r_done;
    assign bus.busy        = r_busy;

endmodule
`default_nettype wire
